// File: rtl/fp_addsub_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : addpkg
//  Description : Shared types for the fp_addsub_sched scheduler and the
//                add_sub_top datapath it feeds: datapath error code, the
//                packed request record and the scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package addpkg;

  localparam int c_MAX_NREQ = 8;

  // Error code reported by the add/sub datapath alongside every result.
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_INVALID   = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_UNDERFLOW = 3'd3,
    ERR_INEXACT   = 3'd4
  } o_err_t;

  // One granted request: both packed IEEE-754 operands plus add/sub select.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } fp_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Index of the set bit of a one-hot vector (zero when no bit is set).
  function automatic logic [2:0] onehot_to_idx(input logic [c_MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < c_MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_sched_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fp_addsub_sched_if
//  Description : Requester-side bundle of fp_addsub_sched.
//                req_*  : per-requester request channel (valid/ready, operands)
//                rsp_*  : per-requester response valid/ready, shared result bus
//                master : requester side, slave : scheduler side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_addsub_sched_if
  import addpkg::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_result;
  o_err_t                rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/fp_addsub_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Grants the first set bit of
//                req at or after ptr, searching circularly.
//                req   : request vector
//                ptr   : highest-priority index
//                grant : one-hot grant
//                found : at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic                    found
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PTR_W'((int'(ptr) + i) % NREQ);
      if (!found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_sched
//  Description : Shares one single-precision add/sub datapath between NREQ
//                requesters. A round-robin grant latches the operands, which
//                drive the datapath for LAT cycles; the datapath result and
//                error code are then registered and returned to the granted
//                requester over its response handshake.
//                clk, rst_n        : clock, asynchronous active-low reset
//                bus               : requester request/response bundle
//                busy              : scheduler not idle
//                sign/exp/sig1,2   : unpacked operands to the datapath
//                opcode            : datapath add(0)/subtract(1)
//                fp_out, err_o     : datapath result and error code
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_sched
  import addpkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_addsub_sched_if.slave      bus,
  output logic                  busy,
  output logic                  sign1,
  output logic                  sign2,
  output logic [7:0]            exp1,
  output logic [7:0]            exp2,
  output logic [22:0]           sig1,
  output logic [22:0]           sig2,
  output logic                  opcode,
  input  logic [31:0]           fp_out,
  input  o_err_t                err_o
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LAT - 1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NREQ - 1);

  sched_state_t     state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fp_req_t          opnd_q, opnd_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  o_err_t           rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  w_grant;
  logic             w_found;
  logic [PTR_W-1:0] w_grant_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (w_grant),
    .found (w_found)
  );

  assign w_grant_idx = PTR_W'(onehot_to_idx(c_MAX_NREQ'(w_grant)));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    opnd_d        = opnd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_err_d     = rsp_err_q;
    bus.req_ready = '0;

    case (state_q)
      IDLE: begin
        // rst_n gates the combinational ready so it reads 0 throughout reset.
        if (w_found && rst_n) begin
          bus.req_ready = w_grant;
          opnd_d        = '{a:  bus.req_a[w_grant_idx],
                            b:  bus.req_b[w_grant_idx],
                            op: bus.req_op[w_grant_idx]};
          gidx_d        = w_grant_idx;
          cnt_d         = '0;
          state_d       = EXEC;
        end
      end

      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        // Operands have now been stable for LAT cycles: sample the datapath.
        if (cnt_q == c_CNT_LAST) begin
          rsp_result_d = fp_out;
          rsp_err_d    = err_o;
          rsp_valid_d  = NREQ'(1) << gidx_q;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready[gidx_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (gidx_q == c_PTR_LAST) ? '0 : gidx_q + 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      opnd_q       <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gidx_q       <= gidx_d;
      cnt_q        <= cnt_d;
      opnd_q       <= opnd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

  // Unpacking is pure bit slicing; ports keep their values until the next grant.
  assign sign1  = opnd_q.a[31];
  assign exp1   = opnd_q.a[30:23];
  assign sig1   = opnd_q.a[22:0];
  assign sign2  = opnd_q.b[31];
  assign exp2   = opnd_q.b[30:23];
  assign sig2   = opnd_q.b[22:0];
  assign opcode = opnd_q.op;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_sched
//  Description : Self-checking bench for fp_addsub_sched. A stand-in datapath
//                answers only once its operand ports have been stable long
//                enough; a scoreboard queue of expected responses is filled on
//                each accept and drained by a negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_sched;
  import addpkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 2;

  typedef struct packed {
    o_err_t      err;
    logic [31:0] res;
  } dp_t;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    o_err_t      err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, sign1, sign2, opcode;
  logic [7:0]  exp1, exp2;
  logic [22:0] sig1, sig2;
  logic [31:0] fp_out;
  o_err_t      err_o;

  fp_addsub_sched_if #(.NREQ(NREQ)) bus ();

  fp_addsub_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .sign1  (sign1),
    .sign2  (sign2),
    .exp1   (exp1),
    .exp2   (exp2),
    .sig1   (sig1),
    .sig2   (sig2),
    .opcode (opcode),
    .fp_out (fp_out),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];
  bit   inflight = 1'b0;
  bit   front_seen = 1'b0;
  int   rr_model = 0;
  int   acc_log[$];
  int   acc_cyc_log[$];
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc++;

  // Reference datapath behaviour: exact sums for the directed vectors,
  // NaN/invalid for any inf/NaN operand, otherwise a deterministic mix.
  function automatic dp_t dp_ref(input logic [31:0] a, input logic [31:0] b, input logic op);
    dp_t d;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) begin
      d.res = 32'h4040_0000; d.err = ERR_NONE;
    end else if (a == 32'h40A0_0000 && b == 32'h4040_0000 && op) begin
      d.res = 32'h4000_0000; d.err = ERR_NONE;
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      d.res = 32'h7FC0_0000; d.err = ERR_INVALID;
    end else begin
      d.res = a ^ {b[15:0], b[31:16]} ^ {op, 31'd0};
      d.err = (a[0] ^ b[0]) ? ERR_INEXACT : ERR_NONE;
    end
    return d;
  endfunction

  // Stand-in datapath: result is only correct once the operand ports have
  // been unchanged for LAT-1 sampled edges, so early capture returns garbage.
  logic [64:0] w_ops;
  logic [64:0] prev_ops = '0;
  int          held = 0;
  dp_t         w_dp;
  logic        w_dp_ok;

  assign w_ops   = {sign1, exp1, sig1, sign2, exp2, sig2, opcode};
  assign w_dp    = dp_ref({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);
  assign w_dp_ok = (w_ops == prev_ops) && (held >= LAT - 1);
  assign fp_out  = w_dp_ok ? w_dp.res : 32'hDEAD_BEEF;
  assign err_o   = w_dp_ok ? w_dp.err : ERR_OVERFLOW;

  always @(posedge clk) begin
    if (w_ops != prev_ops) held <= 1;
    else if (held < 1000) held <= held + 1;
    prev_ops <= w_ops;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: predicts req_ready/busy, fills the scoreboard on accept and
  // compares responses, latency and held operands.
  always @(negedge clk) begin : mon
    int              g;
    logic [NREQ-1:0] er;
    exp_t            e;
    dp_t             d;
    if (rst_n) begin
      er = '0;
      g  = inflight ? -1 : rr_pick(bus.req_valid, rr_model);
      if (g >= 0) er[g] = 1'b1;
      chk("busy", 64'(busy), 64'(inflight));
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      if (g >= 0) begin
        d     = dp_ref(bus.req_a[g], bus.req_b[g], bus.req_op[g]);
        e.r   = g;
        e.a   = bus.req_a[g];
        e.b   = bus.req_b[g];
        e.op  = bus.req_op[g];
        e.res = d.res;
        e.err = d.err;
        e.acc = cyc;
        sb.push_back(e);
        acc_log.push_back(g);
        acc_cyc_log.push_back(cyc);
        inflight   = 1'b1;
        front_seen = 1'b0;
      end

      if (sb.size() == 0) begin
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = sb[0];
        if (cyc > e.acc) begin
          chk("opnd_a", 64'({sign1, exp1, sig1}), 64'(e.a));
          chk("opnd_b", 64'({sign2, exp2, sig2}), 64'(e.b));
          chk("opcode", 64'(opcode), 64'(e.op));
        end
        if (!front_seen && cyc < e.acc + LAT + 1) begin
          chk("rsp_valid_early", 64'(bus.rsp_valid), 64'd0);
        end else begin
          er = '0;
          er[e.r] = 1'b1;
          chk(front_seen ? "rsp_valid_hold" : "rsp_valid_latency", 64'(bus.rsp_valid), 64'(er));
          chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          front_seen = 1'b1;
          if (bus.rsp_ready[e.r]) begin
            void'(sb.pop_front());
            inflight   = 1'b0;
            front_seen = 1'b0;
            rr_model   = (e.r + 1) % NREQ;
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(ERR_NONE));
    chk({tag, "_operands"}, 64'(w_ops), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b, input logic op);
    int t;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    bus.req_op[r]    = op;
    bus.req_valid[r] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[r] && t < 400);
    chk("accept_timeout", 64'(bus.req_ready[r]), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || inflight) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t < 300), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int r, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int bp_rise;
    int t;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed add and subtract
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_idle();
    send(1, 32'h40A0_0000, 32'h4040_0000, 1'b1);
    wait_idle();

    // Round-robin with both requesters continuously pending
    acc_log.delete();
    fork
      begin send(0, $urandom, $urandom, 1'b0); send(0, $urandom, $urandom, 1'b1); end
      begin send(1, $urandom, $urandom, 1'b1); send(1, $urandom, $urandom, 1'b0); end
    join
    wait_idle();
    chk("rr_count", 64'(acc_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("rr_order", 64'(acc_log[k]), 64'(k % 2));

    // Response backpressure with requester 1 waiting
    acc_log.delete();
    acc_cyc_log.delete();
    bp_rise = 0;
    bus.rsp_ready[0] = 1'b0;
    fork
      send(0, $urandom, $urandom, 1'b0);
      begin repeat (2) @(posedge clk); #1; send(1, $urandom, $urandom, 1'b1); end
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rsp_valid[0] && t < 50);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready[0] = 1'b1;
        bp_rise = cyc;
      end
    join
    wait_idle();
    chk("bp_accept_count", 64'(acc_cyc_log.size()), 64'd2);
    if (acc_cyc_log.size() == 2) chk("bp_accept_cycle", 64'(acc_cyc_log[1]), 64'(bp_rise + 1));

    // Reset one cycle into EXEC
    send(0, $urandom, $urandom, 1'b0);
    wait_idle();
    send(1, $urandom, $urandom, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_exec");
    sb.delete();
    inflight   = 1'b0;
    front_seen = 1'b0;
    rr_model   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    acc_log.delete();
    fork
      send(0, $urandom, $urandom, 1'b0);
      send(1, $urandom, $urandom, 1'b0);
    join
    wait_idle();
    chk("post_reset_first_grant", 64'(acc_log[0]), 64'd0);

    // Error propagation: inf - inf
    send(0, 32'h7F80_0000, 32'h7F80_0000, 1'b1);
    wait_idle();

    // Randomised traffic with random response backpressure
    fork
      begin
        fork
          rand_stream(0, 15);
          rand_stream(1, 15);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = NREQ'($urandom);
        end
        bus.rsp_ready = '1;
      end
    join
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fp_addsub_sched.md
# fp_addsub_sched

Sequencer and round-robin arbiter that shares one `add_sub_top` single-precision add/sub datapath between `NREQ` requesters. Each requester issues packed IEEE-754 operands plus an opcode over a valid/ready handshake. The block unpacks the operands into the datapath's sign/exponent/significand ports and holds them stable for `LAT` cycles. It then captures `fp_out`/`err_o` and returns the result to the granted requester over a per-requester valid/ready response channel.

## Interface
- `NREQ`, 2 — number of requesters; legal range 2..8.
- `LAT`, 2 — cycles operands are held before the result is sampled; legal range ≥1.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset; asynchronous and active-low.
- `req_valid` in NREQ — request pending, one bit per requester.
- `req_ready` out NREQ — one-hot acceptance pulse.
- `req_a` in NREQ×32 — operand 1, packed {sign, exp[7:0], sig[22:0]}.
- `req_b` in NREQ×32 — operand 2, same packing as `req_a`.
- `req_op` in NREQ — 0 = add, 1 = subtract.
- `rsp_valid` out NREQ — one-hot; result available for that requester.
- `rsp_ready` in NREQ — requester accepts the result.
- `rsp_result` out 32 — packed result; shared bus, qualified by `rsp_valid`.
- `rsp_err` out `o_err_t` — datapath error code from the shared package.
- `busy` out 1 — high whenever state ≠ IDLE.
- `sign1`, `sign2` out 1 each — datapath operand signs.
- `exp1`, `exp2` out 8 each — datapath operand exponents.
- `sig1`, `sig2` out 23 each — datapath operand significands.
- `opcode` out 1 — datapath add/sub select.
- `fp_out` in 32 — datapath result.
- `err_o` in `o_err_t` — datapath error code.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, grant the first set bit at or after `rr_ptr`, searching circularly.
  - Assert `req_ready[grant]` for exactly that cycle.
  - Latch the granted `req_a`, `req_b` and `req_op` into the operand registers.
  - Load the latency counter with 0 and go to EXEC.
- **EXEC**
  - Operand registers drive the datapath ports continuously.
  - The counter increments every cycle.
  - When the counter reaches `LAT-1`, register `fp_out` into `rsp_result` and `err_o` into `rsp_err`, then go to RESP.
- **RESP**
  - `rsp_valid[grant]` is held high, with `rsp_result`/`rsp_err` stable, until `rsp_ready[grant]` is sampled high.
  - On that cycle: `rr_ptr <= (grant+1) mod NREQ`, then go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- Datapath ports hold their last operand values in IDLE and RESP. They are not cleared after use.
- Requests arriving in EXEC or RESP wait: `req_ready` stays low and the requester must hold `req_valid` and its data.
- Dropping `req_valid` before it is granted is legal; no state is kept for that requester.
- No arithmetic is performed in this block. Unpacking is bit slicing only: sign = [31], exp = [30:23], sig = [22:0].

## Timing
- Reset values:
  - FSM in IDLE; `rr_ptr` = 0.
  - `req_ready`, `rsp_valid`, `busy` = 0.
  - `rsp_result` = 0 and `rsp_err` = the `o_err_t` "no error" enumerator.
  - All datapath operand outputs and `opcode` = 0.
- Latency: accept edge → `rsp_valid` high after LAT+1 cycles. With LAT=2, accept at cycle 0 gives `rsp_valid` at cycle 3.
- Minimum issue interval with `rsp_ready` tied high: LAT+2 cycles.
- `req_ready` is combinational from `req_valid` and state. `rsp_valid` is registered.
- Simultaneous requests: only one is granted per IDLE cycle. The others remain pending.
- `rr_ptr` wraps from NREQ-1 to 0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded and no response is produced. All outputs go to reset values asynchronously.

## Structure
- Shared package `addpkg` holds:
  - `o_err_t` and its no-error enumerator;
  - new `fp_req_t` = {logic [31:0] a, b; logic op};
  - new `sched_state_t` = {IDLE, EXEC, RESP}.
- One sub-module, `rr_arbiter`: parameter NREQ; inputs `req` vector, `ptr`; output one-hot `grant`, plus a `found` flag.
- `add_sub_top` is not instantiated inside this block. It is connected beside it at the next level up.

## Test plan
- **Single add.** Requester 0 sends a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0, with LAT=2.
  - Required: `rsp_valid[0]` exactly 3 cycles after accept, `rsp_result`=0x40400000 (3.0), no-error code.
- **Subtract.** a=0x40A00000 (5.0), b=0x40400000 (3.0), op=1.
  - Required: `rsp_result`=0x40000000 (2.0).
  - Required: `exp1`=0x81, `sig1`=0x200000 and `opcode`=1 held throughout EXEC.
- **Round-robin.** Both requesters hold `req_valid` for 4 operations.
  - Required: grant order 0, 1, 0, 1.
  - Required: `req_ready` is one-hot and never asserted while `busy` is high.
- **Response backpressure.** Hold `rsp_ready[0]` low for 5 cycles.
  - Required: `rsp_valid[0]` and `rsp_result` stable for all 5 cycles.
  - Required: the pending request from requester 1 is not accepted until the cycle after `rsp_ready[0]` rises.
- **Reset mid-operation.** Drop `rst_n` one cycle into EXEC.
  - Required: outputs go to reset values immediately; no `rsp_valid` after release.
  - Required: the next request is granted from `rr_ptr`=0.
- **Error propagation.** Send a=0x7F800000 (+inf), b=0x7F800000, op=1.
  - Required: `rsp_result` equals `fp_out` (NaN) and `rsp_err` equals `err_o`, both sampled at LAT-1.
